// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and helpers for the FIFO port arbiters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int f_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : first set request at or after ptr, scanning upward with wrap
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = f_idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_pos;

   // Scan from the farthest offset down so the nearest hit overwrites last.
   always_comb begin
      idx   = '0;
      any   = 1'b0;
      w_sum = '0;
      w_pos = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
         end
         w_pos = w_sum[IW-1:0];
         if (req[w_pos]) begin
            idx = w_pos;
            any = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb : round-robin packet arbiter sharing one FIFO write port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int WD  = 32,
   parameter int TMO = 255,
   parameter int IW  = f_idx_w(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*WD-1:0] dat,
   input  logic [N-1:0]    last,
   output logic [N-1:0]    ack,
   output logic            fifo_wen,
   output logic [WD-1:0]   fifo_wdat,
   input  logic            fifo_wfull,
   output logic            grant_vld,
   output logic [IW-1:0]   grant_id,
   output logic            tmo_err
);

   localparam int            CW         = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam logic [CW-1:0] c_tmo_m1   = (TMO > 0) ? CW'(TMO - 1) : '0;
   localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

   arb_state_e    state_q,    state_d;
   logic [IW-1:0] owner_q,    owner_d;
   logic [IW-1:0] rr_ptr_q,   rr_ptr_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          tmo_err_q,  tmo_err_d;

   logic [IW-1:0] w_pick_idx;
   logic          w_pick_any;
   logic [WD-1:0] w_dat_arr [N];
   logic          w_beat;
   logic [IW-1:0] w_ptr_after;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_unpack
         assign w_dat_arr[g] = dat[g*WD +: WD];
      end
   endgenerate

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req (req),
      .ptr (rr_ptr_q),
      .idx (w_pick_idx),
      .any (w_pick_any)
   );

   // Gating on the live wfull is what keeps a full FIFO from being overwritten.
   assign w_beat      = (state_q == ST_BURST) & req[owner_q] & ~fifo_wfull;
   assign w_ptr_after = (owner_q == c_last_idx) ? '0 : owner_q + 1'b1;

   assign ack       = w_beat ? (N'(1) << owner_q) : '0;
   assign fifo_wen  = w_beat;
   assign fifo_wdat = w_dat_arr[owner_q];
   assign grant_vld = (state_q == ST_BURST);
   assign grant_id  = owner_q;
   assign tmo_err   = tmo_err_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      tmo_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_pick_any) begin
               owner_d    = w_pick_idx;
               idle_cnt_d = '0;
               state_d    = ST_BURST;
            end
         end
         ST_BURST: begin
            if (w_beat) begin
               idle_cnt_d = '0;
               if (last[owner_q]) begin
                  rr_ptr_d = w_ptr_after;
                  state_d  = ST_IDLE;
               end
            end else if (!req[owner_q] && (TMO != 0)) begin
               // The release lands on the edge where the count would reach TMO.
               if (idle_cnt_q == c_tmo_m1) begin
                  idle_cnt_d = '0;
                  tmo_err_d  = 1'b1;
                  rr_ptr_d   = w_ptr_after;
                  state_d    = ST_IDLE;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arb : directed bench for fifo_wr_arb with a depth-8 FIFO model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req = '0;
   logic [127:0] dat = {32'h0, 32'h0, 32'h0, 32'h55AA_0000};
   logic [3:0]   last = '0;
   logic [3:0]   ack;
   logic         fifo_wen;
   logic [31:0]  fifo_wdat;
   logic         fifo_wfull = 1'b0;
   logic         grant_vld;
   logic [1:0]   grant_id;
   logic         tmo_err;

   fifo_wr_arb #(.N(4), .WD(32), .TMO(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .dat        (dat),
      .last       (last),
      .ack        (ack),
      .fifo_wen   (fifo_wen),
      .fifo_wdat  (fifo_wdat),
      .fifo_wfull (fifo_wfull),
      .grant_vld  (grant_vld),
      .grant_id   (grant_id),
      .tmo_err    (tmo_err)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [32:0] srcq [4][$];
   logic [3:0]  hold = '0;
   logic        force_full = 1'b0;
   logic        use_fifo = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wlog [$];
   int          wcyc [$];
   logic [31:0] mem [$];
   logic [31:0] drain [$];
   logic [3:0]  ack_s = '0;
   logic        wen_s = 1'b0;
   logic [31:0] wdat_s = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] d, input logic l);
      srcq[i].push_back({l, d});
   endtask

   task automatic wait_neg(input int k);
      int g;
      g = 0;
      while (cyc < k && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != k) chk("wait_cycle", 64'(cyc), 64'(k));
   endtask

   task automatic wait_wr(input int n, input int budget);
      for (int g = 0; g < budget && wlog.size() < n; g++) @(negedge clk);
   endtask

   // Sample away from the active edge and check the always-on port invariants.
   always @(negedge clk) begin
      ack_s  = ack;
      wen_s  = fifo_wen;
      wdat_s = fifo_wdat;
      chk("wen_while_full", 64'(fifo_wen & fifo_wfull), 64'd0);
      chk("ack_multi", 64'($countones(ack) > 1), 64'd0);
      chk("ack_vs_wen", 64'(|ack), 64'(fifo_wen));
   end

   // Requester sources, write log and FIFO model, all advanced just after the edge.
   always @(posedge clk) begin
      logic [32:0] e;
      #1;
      cyc = cyc + 1;
      if (wen_s) begin
         wlog.push_back(wdat_s);
         wcyc.push_back(cyc - 1);
         if (use_fifo) mem.push_back(wdat_s);
      end
      for (int i = 0; i < 4; i++) begin
         if (ack_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      if (use_fifo && rd_en && mem.size() > 0) drain.push_back(mem.pop_front());
      fifo_wfull = force_full | (use_fifo && mem.size() == 8);
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() > 0 && !hold[i]) begin
            e = srcq[i][0];
            req[i] = 1'b1;
            last[i] = e[32];
            dat[i*32 +: 32] = e[31:0];
         end else begin
            req[i] = 1'b0;
            last[i] = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int base;
      logic [31:0] exp_q [$];

      rst = 1'b1;
      #3;
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_wen", 64'(fifo_wen), 64'd0);
      chk("rst_gvld", 64'(grant_vld), 64'd0);
      chk("rst_gid", 64'(grant_id), 64'd0);
      chk("rst_tmo", 64'(tmo_err), 64'd0);
      chk("rst_wdat", 64'(fifo_wdat), 64'h55AA_0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single 4-beat packet on requester 2.
      @(negedge clk);
      t0 = cyc + 1;
      base = wlog.size();
      for (int b = 0; b < 4; b++) push(2, 32'hA0 + 32'(b), b == 3);
      wait_neg(t0);
      chk("t1_idle_arb", 64'(grant_vld), 64'd0);
      wait_neg(t0 + 4);
      chk("t1_gvld_hi", 64'(grant_vld), 64'd1);
      wait_neg(t0 + 5);
      chk("t1_gvld_lo", 64'(grant_vld), 64'd0);
      chk("t1_count", 64'(wlog.size() - base), 64'd4);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("t1_dat%0d", b), 64'(wlog[base+b]), 64'(32'hA0 + b));
         chk($sformatf("t1_cyc%0d", b), 64'(wcyc[base+b]), 64'(t0 + 1 + b));
      end

      // Four simultaneous 2-beat packets from reset: order 0,1,2,3 with bubbles.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t0 = cyc + 1;
      base = wlog.size();
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 2; b++) push(p, 32'hB000 + 32'(16 * p + b), b == 1);
      wait_neg(t0 + 12);
      chk("t2_count", 64'(wlog.size() - base), 64'd8);
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 2; b++) begin
            chk($sformatf("t2_dat%0d_%0d", p, b), 64'(wlog[base+2*p+b]), 64'(32'hB000 + 16 * p + b));
            chk($sformatf("t2_cyc%0d_%0d", p, b), 64'(wcyc[base+2*p+b]), 64'(t0 + 1 + 3 * p + b));
         end

      // Three full cycles in the middle of a 5-beat packet on requester 1.
      @(negedge clk);
      t0 = cyc + 1;
      base = wlog.size();
      for (int b = 0; b < 5; b++) push(1, 32'hC0 + 32'(b), b == 4);
      wait_neg(t0 + 2);
      force_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_neg(t0 + 3 + k);
         chk($sformatf("t3_wen%0d", k), 64'(fifo_wen), 64'd0);
         chk($sformatf("t3_ack%0d", k), 64'(ack), 64'd0);
         chk($sformatf("t3_cnt%0d", k), 64'(dut.idle_cnt_q), 64'd0);
      end
      force_full = 1'b0;
      wait_neg(t0 + 9);
      chk("t3_count", 64'(wlog.size() - base), 64'd5);
      for (int b = 0; b < 5; b++) begin
         chk($sformatf("t3_dat%0d", b), 64'(wlog[base+b]), 64'(32'hC0 + b));
         chk($sformatf("t3_cyc%0d", b), 64'(wcyc[base+b]), 64'(t0 + 1 + b + ((b >= 2) ? 3 : 0)));
      end

      // Owner 2 stalls after two beats; watchdog hands over to requester 3.
      @(negedge clk);
      t0 = cyc + 1;
      base = wlog.size();
      for (int b = 0; b < 5; b++) push(2, 32'hD0 + 32'(b), b == 4);
      push(3, 32'hE0, 1'b1);
      wait_neg(t0 + 2);
      hold[2] = 1'b1;
      wait_neg(t0 + 10);
      chk("t4_tmo_early", 64'(tmo_err), 64'd0);
      chk("t4_held", 64'({grant_vld, grant_id}), 64'h6);
      wait_neg(t0 + 11);
      chk("t4_tmo_pulse", 64'(tmo_err), 64'd1);
      chk("t4_released", 64'(grant_vld), 64'd0);
      wait_neg(t0 + 12);
      chk("t4_tmo_done", 64'(tmo_err), 64'd0);
      chk("t4_next_gnt", 64'({grant_vld, grant_id}), 64'h7);
      wait_neg(t0 + 14);
      srcq[2].delete();
      hold[2] = 1'b0;
      chk("t4_count", 64'(wlog.size() - base), 64'd3);
      chk("t4_d0", 64'(wlog[base]), 64'hD0);
      chk("t4_d1", 64'(wlog[base+1]), 64'hD1);
      chk("t4_e0", 64'(wlog[base+2]), 64'hE0);
      chk("t4_e0_cyc", 64'(wcyc[base+2]), 64'(t0 + 12));

      // Move rr_ptr off zero, then reset in the middle of a packet.
      base = wlog.size();
      push(0, 32'h4B00_0000, 1'b1);
      wait_wr(base + 1, 20);
      chk("t5_pre", 64'(wlog[base]), 64'h4B00_0000);
      @(negedge clk);
      t0 = cyc + 1;
      for (int b = 0; b < 5; b++) push(1, 32'hF0 + 32'(b), b == 4);
      wait_neg(t0 + 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_ack", 64'(ack), 64'd0);
      chk("t5_wen", 64'(fifo_wen), 64'd0);
      chk("t5_gvld", 64'(grant_vld), 64'd0);
      chk("t5_gid", 64'(grant_id), 64'd0);
      chk("t5_tmo", 64'(tmo_err), 64'd0);
      chk("t5_wdat", 64'(fifo_wdat), 64'h4B00_0000);
      @(negedge clk);
      srcq[1].delete();
      @(negedge clk);
      rst = 1'b0;
      base = wlog.size();
      push(0, 32'h6060_0000, 1'b1);
      push(3, 32'h6363_0000, 1'b1);
      wait_wr(base + 2, 40);
      chk("t5_first", 64'(wlog[base]), 64'h6060_0000);
      chk("t5_second", 64'(wlog[base+1]), 64'h6363_0000);

      // 20 beats into the depth-8 FIFO model with the reader paused.
      @(negedge clk);
      use_fifo = 1'b1;
      base = wlog.size();
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 5; b++)
            push(p % 2, 32'h7000_0000 + 32'(256 * p + b), b == 4);
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 5; b++) exp_q.push_back(32'h7000_0000 + 32'(256 * p + b));
      repeat (60) @(negedge clk);
      chk("t6_level", 64'(mem.size()), 64'd8);
      chk("t6_writes", 64'(wlog.size() - base), 64'd8);
      chk("t6_full", 64'(fifo_wfull), 64'd1);
      rd_en = 1'b1;
      for (int g = 0; g < 300 && drain.size() < 20; g++) @(negedge clk);
      chk("t6_drained", 64'(drain.size()), 64'd20);
      for (int k = 0; k < 20; k++)
         chk($sformatf("t6_dat%0d", k), 64'(drain[k]), 64'(exp_q[k]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin packet arbiter that shares the single write port of the asynchronous FIFO (`my_fifo`) among N requesters in the write-clock domain. Each requester presents a packet as a stream of beats terminated by `last`. The arbiter grants one requester at a time for a whole packet, drives the FIFO `wen`/`wdat`, and honours `wfull` so no beat is written or lost while the FIFO is full. A watchdog releases a grant whose owner stalls mid-packet.

## Interface
- `N`, 4: number of requesters; 2..16.
- `WD`, 32: data width; must equal the FIFO `WD`.
- `TMO`, 255: idle-beat watchdog limit in cycles; 0 disables the watchdog.
- `IW`, `$clog2(N)`: index width; derived, do not override.

Ports:
- `clk`  in  1  single clock; connects to the FIFO `wclk`.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester beat valid.
- `dat`  in  N*WD  per-requester beat data; requester i occupies `[i*WD +: WD]`.
- `last`  in  N  per-requester end-of-packet flag, qualified by `req`.
- `ack`  out  N  beat accepted; one-hot or zero.
- `fifo_wen`  out  1  to FIFO `wen`.
- `fifo_wdat`  out  WD  to FIFO `wdat`.
- `fifo_wfull`  in  1  from FIFO `wfull`.
- `grant_vld`  out  1  a packet grant is held.
- `grant_id`  out  IW  index of the current owner.
- `tmo_err`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States: IDLE, BURST.
- IDLE:
  - `ack`=0 and `fifo_wen`=0.
  - If `req` is non-zero, pick the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Register that index as `owner` and go to BURST.
  - Arbitration costs one cycle; no beat is accepted in IDLE.
- BURST:
  - `fifo_wen` = `ack[owner]` = `req[owner] & ~fifo_wfull`.
  - `fifo_wdat` = `dat[owner]`, combinational.
  - On an accepted beat with `last[owner]`=1: set `rr_ptr` to `owner+1` (wrapping modulo N) and go to IDLE.
  - If `req[owner]` drops mid-packet, the grant is held and other requesters wait.
- Non-owner `ack` bits are always 0. Requests from non-owners never influence BURST.
- Watchdog:
  - `idle_cnt` (width `$clog2(TMO+1)`) clears on every accepted beat and on entry to BURST.
  - It increments in BURST while `req[owner]`=0. Cycles stalled by `fifo_wfull` do not count.
  - When `idle_cnt` reaches TMO: pulse `tmo_err`, set `rr_ptr` to `owner+1`, go to IDLE.
- `grant_vld` = (state==BURST). `grant_id` = `owner`, held in IDLE at its last value.
- `fifo_wen` is never asserted while `fifo_wfull`=1. This is mandatory: the FIFO writes RAM on `wen` regardless of full.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `owner`=0, `idle_cnt`=0.
  - `ack`=0, `fifo_wen`=0, `fifo_wdat`=`dat[0]` (combinational), `grant_vld`=0, `grant_id`=0, `tmo_err`=0.
- Latency: the first beat of a packet is accepted no earlier than 1 cycle after `req` rises. After that, throughput is 1 beat/cycle while not full.
- Between packets there is exactly one IDLE bubble cycle.
- `fifo_wfull` rises the cycle after the filling write. The combinational gating above covers this lag; no beat is issued against a stale not-full.
- Simultaneous `last` and a watchdog hit is impossible, because the counter clears on an accepted beat. A single-beat packet is legal (`last` on the first beat).
- `rst` mid-packet abandons the packet immediately. No `ack` or `wen` is produced in the reset cycle.

## Structure
- The shared package `fifo_arb_pkg` holds the state encoding (IDLE=0, BURST=1) and the helper function for `IW`.
- Sub-module `rr_pick` (parameter N): combinational; inputs `req[N]` and `ptr[IW]`; outputs `idx[IW]` and `any`. It is reused by future read-side schedulers.

## Test plan
- Single requester (i=2), 4-beat packet `0xA0`..`0xA3`, `req` held from cycle 0 -> `ack[2]` and `fifo_wen` in cycles 1-4, `fifo_wdat` `0xA0`..`0xA3` in order, `grant_vld` falls in cycle 5.
- All 4 requesters each send a 2-beat packet simultaneously -> grant order 0,1,2,3, one idle cycle between packets, 8 FIFO writes in total, no overlap of `ack` bits.
- `fifo_wfull` forced high for 3 cycles mid-packet -> `fifo_wen`=0 and `ack`=0 during those cycles, the stalled beat is written once after release, `idle_cnt` stays 0.
- Owner drops `req` mid-packet with TMO=8 -> `tmo_err` pulses exactly 8 cycles after the drop, the next requester is granted, and the remaining beats of the stalled packet are not written.
- `rst` asserted during beat 2 of a 5-beat packet -> all outputs return to reset values asynchronously; after release, `rr_ptr`=0 and requester 0 wins first.
- Integration with `my_fifo` (WA=3): 20 beats from 2 requesters, reader paused -> the FIFO holds exactly 8 entries, no entry is overwritten, and all 20 beats drain in order after the reader resumes.
